// File: rtl/multi_cycle_multiplier.sv
// Radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
// Signed operands become magnitudes on accept, and the product is negated once at the end.
module multi_cycle_multiplier #(
    parameter logic [4:0] MUL    = 5'b01010,
    parameter logic [4:0] MULH   = 5'b01011,
    parameter logic [4:0] MULHSU = 5'b01100,
    parameter logic [4:0] MULHU  = 5'b01101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [4:0]  ALUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic        r_neg;
    logic        r_lo;
    logic [31:0] r_result;

    logic        w_is_m;
    logic        w_accept;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_sum;
    logic [63:0] w_prod;

    assign w_is_m   = (ALUControl == MUL) || (ALUControl == MULH) ||
                      (ALUControl == MULHSU) || (ALUControl == MULHU);
    assign w_accept = (r_state == IDLE) && start && !flush && w_is_m;

    // Only signed operands contribute a sign; -0x80000000 wraps to 0x80000000, the correct magnitude.
    assign w_a_neg  = ((ALUControl == MULH) || (ALUControl == MULHSU)) && SrcA[31];
    assign w_b_neg  = (ALUControl == MULH) && SrcB[31];
    assign w_mag_a  = w_a_neg ? (~SrcA + 32'd1) : SrcA;
    assign w_mag_b  = w_b_neg ? (~SrcB + 32'd1) : SrcB;

    // Upper half accumulates the multiplicand; the multiplier bits shift out of the lower half.
    assign w_sum    = {1'b0, r_acc[63:32]} + {1'b0, r_mcand};
    assign w_prod   = r_neg ? (~r_acc + 64'd1) : r_acc;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = CALC;
            CALC: if (r_cnt == 5'd31) w_next = SIGN;
            SIGN: w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= 5'd0;
            r_acc    <= 64'd0;
            r_mcand  <= 32'd0;
            r_neg    <= 1'b0;
            r_lo     <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_acc   <= {32'd0, w_mag_b};
                r_mcand <= w_mag_a;
                r_neg   <= w_a_neg ^ w_b_neg;
                r_lo    <= (ALUControl == MUL);
                r_cnt   <= 5'd0;
            end else if (r_state == CALC && !flush) begin
                r_acc <= r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};
                r_cnt <= r_cnt + 5'd1;
            end
            if (r_state == SIGN && !flush) begin
                r_result <= r_lo ? w_prod[31:0] : w_prod[63:32];
            end
        end
    end

    assign busy   = (r_state == CALC) || (r_state == SIGN);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule

// File: doc/multi_cycle_multiplier.md
MULTI_CYCLE_MULTIPLIER -- requirements
Module: multi_cycle_multiplier

Interface
REQ-001 SHALL have parameter MUL, default 5'b01010, ALUControl code for low-word product.
REQ-002 SHALL have parameter MULH, default 5'b01011, code for high word, signed x signed.
REQ-003 SHALL have parameter MULHSU, default 5'b01100, code for high word, signed SrcA x unsigned SrcB.
REQ-004 SHALL have parameter MULHU, default 5'b01101, code for high word, unsigned x unsigned.
REQ-005 SHALL have a single clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 start  input  1  execute-stage request, qualified by an M-code on ALUControl.
REQ-009 flush  input  1  pipeline flush; aborts any operation in flight.
REQ-010 ALUControl  input  5  operation code from the ALU decoder.
REQ-011 SrcA  input  32  multiplicand (rs1 after forwarding).
REQ-012 SrcB  input  32  multiplier (rs2 after forwarding).
REQ-013 busy  output  1  pipeline stall request.
REQ-014 done  output  1  single-cycle pulse; result valid.
REQ-015 result  output  32  selected product word.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, SIGN, DONE.
REQ-017 IDLE: start=1, flush=0 and ALUControl in {MUL, MULH, MULHSU, MULHU} -> latch operands and op, go to CALC; otherwise remain in IDLE.
REQ-018 On accept, SHALL latch the 32-bit magnitudes of the operands, and a negate flag equal to the XOR of the operand signs.
REQ-019 An operand's sign SHALL count only when that operand is signed: SrcA signed for MULH/MULHSU, SrcB signed for MULH only; MUL and MULHU treat both operands as unsigned.
REQ-020 CALC: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, counter 0..31; after iteration 31, go to SIGN.
REQ-021 SIGN: two's-complement negate the 64-bit product if the negate flag is set; load result with bits [31:0] for MUL, else bits [63:32]; go to DONE.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-023 Latency: start sampled in cycle 0 -> done=1 in cycle 34.
REQ-024 busy SHALL be 1 in CALC and SIGN, and 0 in IDLE and DONE.
REQ-025 SHALL ignore start in any state other than IDLE, including DONE; back-to-back operations therefore run at a 35-cycle initiation interval.
REQ-026 SrcA, SrcB and ALUControl changes after accept SHALL NOT affect the operation in flight.
REQ-027 flush=1 in any state -> IDLE at the next edge; done is not asserted and result is unchanged.
REQ-028 flush and start both high in IDLE -> flush wins; nothing is accepted.
REQ-029 result SHALL hold its last value until the next SIGN state; it is meaningful only while done=1.
REQ-030 Operand 0x80000000 signed SHALL use magnitude 2^31 (unsigned 32-bit), with no overflow.

Reset
REQ-031 rst=0 SHALL force, asynchronously: state IDLE, busy=0, done=0, result=0, counter=0, accumulator=0, negate flag=0.
REQ-032 Reset deasserted mid-operation: the operation is lost; the block stays in IDLE until the next valid start.

Verification
REQ-033 MUL, SrcA=7, SrcB=0xFFFFFFFD -> done in cycle 34, result=0xFFFFFFEB; busy high in cycles 1-33.
REQ-034 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 MULHSU, SrcA=0xFFFFFFFF (-1), SrcB=0xFFFFFFFF -> result=0xFFFFFFFF; MULHSU 2 x 0x80000000 -> 0x00000001.
REQ-036 flush in cycle 10 -> busy=0 from cycle 11, no done, result keeps its prior value; a new start in cycle 12 completes normally in cycle 46.
REQ-037 start held high with changing operands during CALC -> only the first operation is computed; a single done pulse; the re-request is accepted only from IDLE (cycle 35).
REQ-038 rst asserted in cycle 20 -> all outputs 0 immediately; start with ALUControl=ADD after release -> no response.
